// File: rtl/persiana_plant_model.sv
// persiana_plant_model: blind plant emulator turning subir/bajar motor commands into Ssup/Smed/Sinf.
// Optional feature: define PLANT_SPINUP_EN to double the first step period after leaving IDLE.
module persiana_plant_model #(
  parameter int POS_MAX    = 100,
  parameter int MID_POS    = 50,
  parameter int SENSOR_WIN = 2,
  parameter int STEP_DIV   = 4,
  parameter int INIT_POS   = 0,
  parameter int POS_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, FAULT} state_t;

  localparam int PRE_W = $clog2(2 * STEP_DIV);
  localparam logic [PRE_W-1:0] STEP_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0] SPIN_LAST = PRE_W'(2 * STEP_DIV - 1);
`ifdef PLANT_SPINUP_EN
  localparam logic SPINUP = 1'b1;
`else
  localparam logic SPINUP = 1'b0;
`endif
  localparam logic [POS_W-1:0] TOP      = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT     = POS_W'(INIT_POS);
  localparam int               MID_LO_I = (MID_POS > SENSOR_WIN) ? MID_POS - SENSOR_WIN : 0;
  localparam logic [POS_W-1:0] MID_LO   = POS_W'(MID_LO_I);
  localparam logic [POS_W-1:0] MID_HI   = POS_W'(MID_POS + SENSOR_WIN);

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             first_step;
  logic [PRE_W-1:0] step_last;
  logic             at_step;
  logic [POS_W-1:0] pos_up;
  logic [POS_W-1:0] pos_dn;

  // first_step only stays set while the spin-up step is pending
  assign step_last = first_step ? SPIN_LAST : STEP_LAST;
  assign at_step   = (prescaler == step_last);
  assign pos_up    = pos + POS_W'(1);
  assign pos_dn    = pos - POS_W'(1);

  assign Ssup = (pos == TOP);
  assign Sinf = (pos == '0);
  assign Smed = (pos >= MID_LO) && (pos <= MID_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= INIT;
      prescaler  <= '0;
      first_step <= 1'b0;
      moving     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (subir && bajar) begin
            state  <= FAULT;
            fault  <= 1'b1;
            moving <= 1'b0;
          end else if (subir && (pos < TOP)) begin
            state      <= UP;
            moving     <= 1'b1;
            prescaler  <= '0;
            first_step <= SPINUP;
          end else if (bajar && (pos != '0)) begin
            state      <= DOWN;
            moving     <= 1'b1;
            prescaler  <= '0;
            first_step <= SPINUP;
          end
        end

        UP: begin
          if (subir && bajar) begin
            state  <= FAULT;
            fault  <= 1'b1;
            moving <= 1'b0;
          end else if (bajar) begin
            prescaler  <= '0;
            first_step <= 1'b0;
            if (pos != '0) begin
              state <= DOWN;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else if (!subir) begin
            state      <= IDLE;
            moving     <= 1'b0;
            prescaler  <= '0;
            first_step <= 1'b0;
          end else if (at_step) begin
            pos        <= pos_up;
            prescaler  <= '0;
            first_step <= 1'b0;
            if (pos_up == TOP) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        DOWN: begin
          if (subir && bajar) begin
            state  <= FAULT;
            fault  <= 1'b1;
            moving <= 1'b0;
          end else if (subir) begin
            prescaler  <= '0;
            first_step <= 1'b0;
            if (pos < TOP) begin
              state <= UP;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else if (!bajar) begin
            state      <= IDLE;
            moving     <= 1'b0;
            prescaler  <= '0;
            first_step <= 1'b0;
          end else if (at_step) begin
            pos        <= pos_dn;
            prescaler  <= '0;
            first_step <= 1'b0;
            if (pos_dn == '0) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        FAULT: begin
          moving <= 1'b0;
          fault  <= 1'b1;
        end

        default: begin
          state  <= FAULT;
          fault  <= 1'b1;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule
